lut_addsub_pipe: RTL and testbench

//   Parametrised, pipelined signed add/sub unit; successor to the fixed 8-bit single-op LUT subtractor.

---
 rtl/lut_addsub_pipe.sv | 184 ++++++++++++++++++
 tb/tb_lut_addsub_pipe.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_addsub_pipe.sv
// ---------------------------------------------------------------------------
// lut_addsub_pipe
//   Pipelined two's-complement add/subtract unit with valid/ready flow control
//   on both sides. The operation (a+b or a-b) is chosen per transaction. The
//   unit also reports signed overflow of the exact result.
//
//   The sum is formed once, on acceptance, at WIDTH+1 bits. The result then
//   travels through LAT holding stages. The last stage drives y, ovf and
//   out_valid directly from flops.
//
//   Each stage has its own load enable. A stage can load when it is empty or
//   when the stage after it is moving on. The chain is resolved from out_ready
//   backwards, so a stalled output still lets empty upstream stages fill
//   (bubbles collapse).
//
// Parameters
//   WIDTH  operand/result width in bits (>= 2), signed
//   LAT    number of pipeline stages from acceptance to output (>= 1)
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   synchronous active-low reset
//   in_valid   in   operand transaction offered
//   in_ready   out  unit accepts this cycle (combinational from out_ready)
//   op         in   0 = a+b, 1 = a-b
//   a, b       in   signed operands
//   out_valid  out  y/ovf hold a result
//   out_ready  in   consumer takes the result this cycle
//   y          out  result (wrapped, or clamped when saturation is built in)
//   ovf        out  exact result does not fit WIDTH signed bits
//
// Build option
//   LUT_ADDSUB_SAT_EN  when defined, an overflowing result clamps to the most
//                      positive or most negative value. When undefined, y
//                      wraps modulo 2^WIDTH. ovf is reported in both builds.
// ---------------------------------------------------------------------------
module lut_addsub_pipe #(
  parameter int WIDTH = 8,
  parameter int LAT   = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);

`ifdef LUT_ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  // Exact sum/difference at WIDTH+1 bits. Negating the most negative b
  // cannot overflow at this width.
  function automatic logic [WIDTH:0] addsub_exact(
    input logic             sub,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] z
  );
    logic [WIDTH:0] xe;
    logic [WIDTH:0] ze;
    xe = {x[WIDTH-1], x};
    ze = {z[WIDTH-1], z};
    if (sub) begin
      addsub_exact = xe - ze;
    end else begin
      addsub_exact = xe + ze;
    end
  endfunction

  // Pipeline stage state
  logic [LAT-1:0]            vld_q;
  logic [LAT-1:0]            vld_d;
  logic [LAT-1:0][WIDTH-1:0] res_q;
  logic [LAT-1:0][WIDTH-1:0] res_d;
  logic [LAT-1:0]            ovf_q;
  logic [LAT-1:0]            ovf_d;

  // Per-stage load enables and the arithmetic on the input side
  logic [LAT-1:0] en_s;
  logic           chain_s;
  logic           accept_s;
  logic [WIDTH:0] exact_s;
  logic [WIDTH-1:0] res_s;
  logic           ovf_s;

  // Load-enable chain, resolved from the output back to stage 0
  always_comb begin
    en_s    = {LAT{1'b0}};
    chain_s = out_ready;
    for (int i = LAT - 1; i >= 0; i--) begin
      // Stage i may load when it is empty or its content moves downstream
      chain_s = !vld_q[i] || chain_s;
      en_s[i] = chain_s;
    end
  end

  // Input handshake; held off entirely while reset is asserted
  always_comb begin
    in_ready = reset && en_s[0];
    accept_s = in_valid && in_ready;
  end

  // Result and overflow of the operands currently on the input
  always_comb begin
    exact_s = addsub_exact(op, a, b);
    // The sign of the exact value disagrees with the truncated sign on overflow
    ovf_s   = exact_s[WIDTH] ^ exact_s[WIDTH-1];
`ifdef LUT_ADDSUB_SAT_EN
    if (ovf_s) begin
      if (exact_s[WIDTH]) begin
        res_s = SAT_MIN;
      end else begin
        res_s = SAT_MAX;
      end
    end else begin
      res_s = exact_s[WIDTH-1:0];
    end
`else
    res_s = exact_s[WIDTH-1:0];
`endif
  end

  // Next-state for all stages
  always_comb begin
    vld_d = vld_q;
    res_d = res_q;
    ovf_d = ovf_q;
    if (en_s[0]) begin
      vld_d[0] = accept_s;
      // Payload only changes on a real transfer, so idle stages keep old data
      if (accept_s) begin
        res_d[0] = res_s;
        ovf_d[0] = ovf_s;
      end else begin
        res_d[0] = res_q[0];
        ovf_d[0] = ovf_q[0];
      end
    end else begin
      vld_d[0] = vld_q[0];
    end
    for (int i = 1; i < LAT; i++) begin
      if (en_s[i]) begin
        vld_d[i] = vld_q[i-1];
        if (vld_q[i-1]) begin
          res_d[i] = res_q[i-1];
          ovf_d[i] = ovf_q[i-1];
        end else begin
          res_d[i] = res_q[i];
          ovf_d[i] = ovf_q[i];
        end
      end else begin
        vld_d[i] = vld_q[i];
      end
    end
  end

  // Stage registers; reset drops every in-flight transaction and clears y/ovf
  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_q <= {LAT{1'b0}};
      res_q <= '0;
      ovf_q <= {LAT{1'b0}};
    end else begin
      vld_q <= vld_d;
      res_q <= res_d;
      ovf_q <= ovf_d;
    end
  end

  // The last stage is the output register
  always_comb begin
    out_valid = vld_q[LAT-1];
    y         = res_q[LAT-1];
    ovf       = ovf_q[LAT-1];
  end

endmodule

// File: tb/tb_lut_addsub_pipe.sv
// ---------------------------------------------------------------------------
// tb_lut_addsub_pipe
//   Checks lut_addsub_pipe using several methods:
//     - a table of hand-computed vectors (WIDTH=8, LAT=2)
//     - streaming, stall and reset sequences
//     - two random instances (WIDTH=16, LAT=1 and LAT=4) with random
//       out_ready
//   A queue scoreboard is fed from an integer reference model. The model
//   follows the saturation build option.
// ---------------------------------------------------------------------------
module tb_lut_addsub_pipe;

`ifdef LUT_ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       op;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       ovf;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int out_cnt = 0;
  logic [32:0] sb_q[$];

  typedef struct {
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] ey;
    logic       eovf;
  } vec_t;

  vec_t vecs[10];

  lut_addsub_pipe #(.WIDTH(8), .LAT(2)) u_dut (
    .clock(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Integer reference: returns {ovf, y zero-extended to 32 bits}
  function automatic logic [32:0] ref_calc(input int w, input bit sub, input int as, input int bs);
    int exact;
    int maxv;
    int minv;
    int r;
    bit o;
    logic [31:0] rr;
    exact = sub ? (as - bs) : (as + bs);
    maxv  = (1 << (w - 1)) - 1;
    minv  = -(1 << (w - 1));
    o     = (exact > maxv) || (exact < minv);
    r     = exact;
    if (SAT && o) r = (exact > 0) ? maxv : minv;
    r  = r & ((1 << w) - 1);
    rr = r;
    return {o, rr};
  endfunction

  // Scoreboard for the main instance. Transfers happen at the next rising
  // edge, so handshakes are sampled on the falling edge.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        out_cnt++;
        if (sb_q.size() == 0) begin
          check("sb_unexpected_output", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("sb_y", {24'd0, y}, e[31:0]);
          check("sb_ovf", {31'd0, ovf}, {31'd0, e[32]});
        end
      end
      if (in_valid && in_ready) begin
        acc_cnt++;
        sb_q.push_back(ref_calc(8, op, int'($signed(a)), int'($signed(b))));
      end
    end
  end

  // Random instances: WIDTH=16, LAT=1 and LAT=4
  for (genvar k = 0; k < 2; k++) begin : g_rand
    localparam int RLAT = (k == 0) ? 1 : 4;
    localparam int NTX = 200;
    logic        rrst;
    logic        rv;
    logic        rrdy;
    logic        rop;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        ovld;
    logic        rordy;
    logic [15:0] oy;
    logic        oovf;
    logic [32:0] exp_q[$];
    bit          acc_last = 1'b0;
    bit          done_r = 1'b0;
    int          nrecv = 0;
    int          noffer = 0;

    lut_addsub_pipe #(.WIDTH(16), .LAT(RLAT)) u_rdut (
      .clock(clk), .reset(rrst), .in_valid(rv), .in_ready(rrdy),
      .op(rop), .a(ra), .b(rb), .out_valid(ovld), .out_ready(rordy),
      .y(oy), .ovf(oovf)
    );

    always @(negedge clk) begin
      logic [32:0] e;
      if (!rrst) begin
        exp_q.delete();
        acc_last = 1'b0;
      end else begin
        if (ovld && rordy) begin
          nrecv++;
          if (exp_q.size() == 0) begin
            check(k == 0 ? "rand_unexpected_lat1" : "rand_unexpected_lat4", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check(k == 0 ? "rand_y_lat1" : "rand_y_lat4", {16'd0, oy}, e[31:0]);
            check(k == 0 ? "rand_ovf_lat1" : "rand_ovf_lat4", {31'd0, oovf}, {31'd0, e[32]});
          end
        end
        acc_last = rv && rrdy;
        if (acc_last) exp_q.push_back(ref_calc(16, rop, int'($signed(ra)), int'($signed(rb))));
      end
    end

    initial begin
      rrst = 1'b0; rv = 1'b0; rop = 1'b0; ra = 16'd0; rb = 16'd0; rordy = 1'b0;
      repeat (16) @(posedge clk);
      #1 rrst = 1'b1;
      for (int cyc = 0; cyc < 3000 && nrecv < NTX; cyc++) begin
        @(posedge clk);
        #1;
        if (rv && acc_last) rv = 1'b0;
        if (!rv && noffer < NTX && $urandom_range(0, 3) != 0) begin
          rv  = 1'b1;
          rop = 1'($urandom_range(0, 1));
          ra  = 16'($urandom);
          rb  = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
          noffer++;
        end
        rordy = ($urandom_range(0, 3) != 0);
      end
      check(k == 0 ? "rand_count_lat1" : "rand_count_lat4", nrecv, NTX);
      check(k == 0 ? "rand_left_lat1" : "rand_left_lat4", exp_q.size(), 32'd0);
      done_r = 1'b1;
    end
  end

  initial begin
    int c0;
    int a0;
    logic [7:0] y_hold;

    vecs[0] = '{1'b1, 8'h01, 8'hFD, 8'h04, 1'b0};
    vecs[1] = '{1'b0, 8'h7F, 8'h01, SAT ? 8'h7F : 8'h80, 1'b1};
    vecs[2] = '{1'b1, 8'h80, 8'h01, SAT ? 8'h80 : 8'h7F, 1'b1};
    vecs[3] = '{1'b1, 8'h00, 8'h80, SAT ? 8'h7F : 8'h80, 1'b1};
    vecs[4] = '{1'b0, 8'h80, 8'h80, SAT ? 8'h80 : 8'h00, 1'b1};
    vecs[5] = '{1'b0, 8'h64, 8'hCE, 8'h32, 1'b0};
    vecs[6] = '{1'b1, 8'hFF, 8'h7F, 8'h80, 1'b0};
    vecs[7] = '{1'b0, 8'h7F, 8'h7F, SAT ? 8'h7F : 8'hFE, 1'b1};
    vecs[8] = '{1'b1, 8'h05, 8'h05, 8'h00, 1'b0};
    vecs[9] = '{1'b1, 8'h80, 8'h80, 8'h00, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; op = 1'b0; a = 8'd0; b = 8'd0; out_ready = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_y", {24'd0, y}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;
    #1 check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Table vectors: single transaction, out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1; op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
      #1 check("vec_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      check("vec_out_valid_early", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
      check("vec_out_valid", {31'd0, out_valid}, 32'd1);
      check("vec_y", {24'd0, y}, {24'd0, vecs[i].ey});
      check("vec_ovf", {31'd0, ovf}, {31'd0, vecs[i].eovf});
      @(posedge clk);
      #1 check("vec_out_valid_pulse", {31'd0, out_valid}, 32'd0);
    end

    // Back-to-back stream of 20 with full flow
    c0 = out_cnt; a0 = acc_cnt;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1; op = 1'($urandom_range(0, 1)); a = 8'($urandom); b = 8'($urandom);
      #1 check("stream_in_ready", {31'd0, in_ready}, 32'd1);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("stream_accepts", acc_cnt - a0, 32'd20);
    check("stream_outputs", out_cnt - c0, 32'd20);

    // Stall: continuous offers with out_ready low
    c0 = out_cnt; a0 = acc_cnt;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1; op = 1'($urandom_range(0, 1)); a = 8'($urandom); b = 8'($urandom);
    end
    @(posedge clk);
    #1;
    check("stall_accepts", acc_cnt - a0, 32'd2);
    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    check("stall_out_valid", {31'd0, out_valid}, 32'd1);
    y_hold = y;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check("stall_y_hold", {23'd0, out_valid, y}, {23'd0, 1'b1, y_hold});
    end
    // Full pipe: out_ready opens the input in the same cycle
    out_ready = 1'b1;
    #1 check("full_pass_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      op = 1'($urandom_range(0, 1)); a = 8'($urandom); b = 8'($urandom);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("drain_balance", out_cnt - c0, acc_cnt - a0);
    check("drain_empty", sb_q.size(), 32'd0);

    // Reset with two in flight
    out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b1; op = 1'b0; a = 8'd3; b = 8'd4;
    @(posedge clk);
    #1 a = 8'd5; b = 8'd6;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("inflight_out_valid", {31'd0, out_valid}, 32'd1);
    c0 = out_cnt;
    rst_n = 1'b0;
    #1 check("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_y", {24'd0, y}, 32'd0);
    check("rst_mid_ovf", {31'd0, ovf}, 32'd0);
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("rst_no_stale", out_cnt - c0, 32'd0);
    check("rst_no_stale_valid", {31'd0, out_valid}, 32'd0);

    for (int i = 0; i < 5000 && !(g_rand[0].done_r && g_rand[1].done_r); i++) @(posedge clk);
    check("rand_done", {30'd0, g_rand[1].done_r, g_rand[0].done_r}, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
